// File: rtl/passcode_checker.sv
// Passcode checker: collects NUM_DIGITS digits, grants or denies, and locks out after repeated failures.
// Optional inter-digit timeout is enabled by defining PASSCODE_TIMEOUT_EN.
module passcode_checker #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned ENTRY_TIMEOUT  = 5000
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic [3:0]                        Digit_in,
  input  logic                              Digit_valid,
  input  logic                              Clear,
  input  logic [4*NUM_DIGITS-1:0]           Passcode_in,
  output logic                              Access_granted,
  output logic                              Access_denied,
  output logic                              Locked,
  output logic                              Timeout,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   Digit_count,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0] Attempts_left
);

  localparam int unsigned CW = $clog2(NUM_DIGITS + 1);
  localparam int unsigned AW = $clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCollect = 2'd1;
  localparam logic [1:0] StLockout = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          mismatch_q, mismatch_d;
  logic [AW-1:0] attempts_q, attempts_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          granted_q, granted_d;
  logic          denied_q, denied_d;
  logic          timeout_q, timeout_d;

  logic [3:0]    exp_digit;
  logic          digit_bad;
  logic          accept;

`ifdef PASSCODE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(ENTRY_TIMEOUT + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          expired;
  assign expired = (state_q == StCollect) && (timer_q == TW'(ENTRY_TIMEOUT - 1));
`else
  logic unused_cfg;
  assign unused_cfg = ^ENTRY_TIMEOUT;
`endif

  // Select the passcode nibble for the current digit position (first digit in MSB nibble).
  always_comb begin
    exp_digit = 4'h0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (count_q == CW'(i)) exp_digit = Passcode_in[4*(NUM_DIGITS-1-i) +: 4];
    end
  end

  assign digit_bad = (Digit_in > 4'd9) || (Digit_in != exp_digit);
  assign accept    = Digit_valid && !Clear && (state_q != StLockout);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mismatch_d = mismatch_q;
    attempts_d = attempts_q;
    lock_cnt_d = lock_cnt_q;
    granted_d  = 1'b0;
    denied_d   = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      StLockout: begin
        count_d = '0;
        if (lock_cnt_q == LW'(LOCKOUT_CYCLES - 1)) begin
          state_d    = StIdle;
          attempts_d = AW'(MAX_ATTEMPTS);
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: begin
        if (Clear) begin
          state_d    = StIdle;
          count_d    = '0;
          mismatch_d = 1'b0;
        end else if (accept) begin
          if (count_q == CW'(NUM_DIGITS - 1)) begin
            count_d    = '0;
            mismatch_d = 1'b0;
            state_d    = StIdle;
            if (!(mismatch_q || digit_bad)) begin
              granted_d  = 1'b1;
              attempts_d = AW'(MAX_ATTEMPTS);
            end else begin
              denied_d = 1'b1;
              if (attempts_q > AW'(1)) begin
                attempts_d = attempts_q - 1'b1;
              end else begin
                // Last allowed failure: enter lockout, nothing left until it expires.
                attempts_d = '0;
                lock_cnt_d = '0;
                state_d    = StLockout;
              end
            end
          end else begin
            count_d    = count_q + 1'b1;
            mismatch_d = mismatch_q || digit_bad;
            state_d    = StCollect;
          end
`ifdef PASSCODE_TIMEOUT_EN
        end else if (expired) begin
          state_d    = StIdle;
          count_d    = '0;
          mismatch_d = 1'b0;
          timeout_d  = 1'b1;
`endif
        end
      end
    endcase
  end

`ifdef PASSCODE_TIMEOUT_EN
  // Timer restarts on every accepted digit and only runs while an entry is in progress.
  assign timer_d = (state_d == StCollect && !accept) ? timer_q + 1'b1 : '0;

  always_ff @(posedge Clk) begin
    if (Rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      mismatch_q <= 1'b0;
      attempts_q <= AW'(MAX_ATTEMPTS);
      lock_cnt_q <= '0;
      granted_q  <= 1'b0;
      denied_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mismatch_q <= mismatch_d;
      attempts_q <= attempts_d;
      lock_cnt_q <= lock_cnt_d;
      granted_q  <= granted_d;
      denied_q   <= denied_d;
      timeout_q  <= timeout_d;
    end
  end

  assign Access_granted = granted_q;
  assign Access_denied  = denied_q;
  assign Timeout        = timeout_q;
  assign Locked         = (state_q == StLockout);
  assign Digit_count    = count_q;
  assign Attempts_left  = attempts_q;

endmodule

// File: tb/tb_passcode_checker.sv
// Scoreboard bench for passcode_checker: stimulus pushes expected pulses, a monitor pops and checks.
module tb_passcode_checker;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [3:0]  Digit_in = 4'h0;
  logic        Digit_valid = 1'b0;
  logic        Clear = 1'b0;
  logic [15:0] Passcode_in = 16'h5261;
  logic        Access_granted, Access_denied, Locked, Timeout;
  logic [2:0]  Digit_count;
  logic [1:0]  Attempts_left;

  int tests = 0;
  int errors = 0;

  typedef struct {
    logic g;
    logic d;
    logic t;
    logic l;
    int   att;  // -1: not checked
  } exp_t;

  exp_t exp_q[$];

  passcode_checker #(
    .NUM_DIGITS    (4),
    .MAX_ATTEMPTS  (3),
    .LOCKOUT_CYCLES(16),
    .ENTRY_TIMEOUT (32)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Digit_in      (Digit_in),
    .Digit_valid   (Digit_valid),
    .Clear         (Clear),
    .Passcode_in   (Passcode_in),
    .Access_granted(Access_granted),
    .Access_denied (Access_denied),
    .Locked        (Locked),
    .Timeout       (Timeout),
    .Digit_count   (Digit_count),
    .Attempts_left (Attempts_left)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: any result pulse must match the oldest expected entry.
  always @(negedge Clk) begin
    if (!Rst && (Access_granted || Access_denied || Timeout)) begin
      if (exp_q.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL unexpected_pulse: got g=%0b d=%0b t=%0b, expected none",
                 Access_granted, Access_denied, Timeout);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_gdtl", {Access_granted, Access_denied, Timeout, Locked},
              {e.g, e.d, e.t, e.l});
        if (e.att >= 0) check("pulse_attempts", int'(Attempts_left), e.att);
      end
    end
  end

  task automatic expect_pulse(input logic g, input logic d, input logic t, input logic l,
                              input int att);
    exp_t e;
    e.g = g; e.d = d; e.t = t; e.l = l; e.att = att;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic send(input logic [3:0] d);
    Digit_in = d;
    Digit_valid = 1'b1;
    tick(1);
    Digit_valid = 1'b0;
  endtask

  task automatic send_code(input logic [15:0] c);
    for (int i = 0; i < 4; i++) send(c[4*(3-i) +: 4]);
  endtask

  initial begin
    int n;
    int bad;
    tick(3);
    Rst = 1'b0;
    check("reset_outputs", {Access_granted, Access_denied, Locked, Timeout}, 0);
    check("reset_count", int'(Digit_count), 0);
    check("reset_attempts", int'(Attempts_left), 3);

    // 1: correct code
    expect_pulse(1, 0, 0, 0, 3);
    send_code(16'h5261);
    check("t1_count", int'(Digit_count), 0);
    tick(2);

    // 2: wrong then right, back to back (next entry starts on the pulse cycle)
    expect_pulse(0, 1, 0, 0, 2);
    send_code(16'h5260);
    expect_pulse(1, 0, 0, 0, 3);
    send_code(16'h5261);
    tick(2);

    // 3: three failures -> lockout
    expect_pulse(0, 1, 0, 0, 2);
    send_code(16'h1111);
    expect_pulse(0, 1, 0, 0, 1);
    send_code(16'h1111);
    expect_pulse(0, 1, 0, 1, -1);
    send_code(16'h1111);
    check("t3_locked_rise", int'(Locked), 1);
    n = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (!Locked) break;
      n++;
      if (Digit_count != 3'd0) bad++;
      Digit_in = 4'h5;
      Digit_valid = 1'b1;
      Clear = (i == 5);
      tick(1);
    end
    Digit_valid = 1'b0;
    Clear = 1'b0;
    check("t3_locked_cycles", n, 16);
    check("t3_count_in_lockout", bad, 0);
    check("t3_count_after", int'(Digit_count), 0);
    check("t3_attempts_after", int'(Attempts_left), 3);
    expect_pulse(1, 0, 0, 0, 3);
    send_code(16'h5261);
    tick(2);

    // 4: Clear beats a simultaneous digit
    send(4'h5);
    send(4'h2);
    check("t4_count_before_clear", int'(Digit_count), 2);
    Digit_in = 4'h6;
    Digit_valid = 1'b1;
    Clear = 1'b1;
    tick(1);
    Digit_valid = 1'b0;
    Clear = 1'b0;
    check("t4_count_after_clear", int'(Digit_count), 0);
    tick(2);
    expect_pulse(1, 0, 0, 0, 3);
    send_code(16'h5261);
    tick(2);

    // 5: invalid symbol counts as a digit; reset during lockout
    expect_pulse(0, 1, 0, 0, 2);
    send_code(16'h5F61);
    expect_pulse(0, 1, 0, 0, 1);
    send_code(16'h0000);
    expect_pulse(0, 1, 0, 1, -1);
    send_code(16'h9999);
    tick(3);
    check("t5_locked_mid", int'(Locked), 1);
    Rst = 1'b1;
    tick(1);
    Rst = 1'b0;
    check("t5_locked_after_rst", int'(Locked), 0);
    check("t5_attempts_after_rst", int'(Attempts_left), 3);
    check("t5_count_after_rst", int'(Digit_count), 0);
    tick(2);

`ifdef PASSCODE_TIMEOUT_EN
    // 6: inter-digit timeout
    expect_pulse(0, 0, 1, 0, 3);
    send(4'h5);
    send(4'h2);
    check("t6_count_before", int'(Digit_count), 2);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (Timeout) break;
      n++;
      tick(1);
    end
    check("t6_timeout_cycles", n, 32);
    check("t6_count_after", int'(Digit_count), 0);
    tick(2);
`endif

    tick(3);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
